// File: rtl/neureka_accumulator_streamout.sv
// rtl/neureka_accumulator_streamout.sv - drains the accumulator buffer as strobed valid/ready beats
module neureka_accumulator_streamout #(
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_WORDS    = 32,
    parameter int WIDTH_FACTOR = 8,
    localparam int LEN_WIDTH   = $clog2(NUM_WORDS + 1),
    localparam int NUM_BEATS   = NUM_WORDS / WIDTH_FACTOR
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [LEN_WIDTH-1:0]               len_i,
    input  logic                               clear_after_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0]    rdata_all_i,
    output logic                               clear_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [WIDTH_FACTOR*DATA_WIDTH-1:0] data_o,
    output logic [WIDTH_FACTOR-1:0]            strb_o,
    output logic                               last_o
);

    localparam int BEAT_W = WIDTH_FACTOR * DATA_WIDTH;
    localparam int NBW    = $clog2(NUM_BEATS + 1);
    localparam int RW     = (WIDTH_FACTOR > 1) ? $clog2(WIDTH_FACTOR) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_FLUSH, S_CLEAR, S_DONE} state_t;

    state_t                state, state_next;
    logic [NBW-1:0]        k, nbeats_q, nbeats_calc;
    logic [RW-1:0]         rem_q, rem_calc;
    logic                  clear_q;
    logic [LEN_WIDTH-1:0]  len_sat;
    logic                  handshake, load, last_load;
    logic [BEAT_W-1:0]     chunk;
    logic [WIDTH_FACTOR-1:0] part_mask;

    always_comb begin
        len_sat     = (len_i > LEN_WIDTH'(NUM_WORDS)) ? LEN_WIDTH'(NUM_WORDS) : len_i;
        rem_calc    = RW'(len_sat % LEN_WIDTH'(WIDTH_FACTOR));
        nbeats_calc = NBW'(len_sat / LEN_WIDTH'(WIDTH_FACTOR)) + NBW'(rem_calc != '0);
    end

    // The output register refills whenever it is empty or being drained this cycle.
    always_comb begin
        handshake = valid_o & ready_i;
        load      = (state == S_DRAIN) && (!valid_o || ready_i);
        last_load = load && (k == nbeats_q - NBW'(1));
        chunk     = '0;
        for (int b = 0; b < NUM_BEATS; b++) begin
            if (k == NBW'(b)) chunk = rdata_all_i[b*BEAT_W +: BEAT_W];
        end
        part_mask = '0;
        for (int i = 0; i < WIDTH_FACTOR; i++) begin
            part_mask[i] = (i < int'(rem_q));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_o     = (state != S_IDLE);
        clear_o    = (state == S_CLEAR);
        done_o     = (state == S_DONE);
        case (state)
            S_IDLE:  if (start_i) state_next = (len_sat != '0) ? S_DRAIN : S_DONE;
            S_DRAIN: if (last_load) state_next = S_FLUSH;
            S_FLUSH: if (handshake) state_next = clear_q ? S_CLEAR : S_DONE;
            S_CLEAR: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k        <= '0;
            nbeats_q <= '0;
            rem_q    <= '0;
            clear_q  <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            strb_o   <= '0;
            last_o   <= 1'b0;
        end else begin
            if (state == S_IDLE && start_i) begin
                nbeats_q <= nbeats_calc;
                rem_q    <= rem_calc;
                clear_q  <= clear_after_i;
                k        <= '0;
            end
            if (load) begin
                data_o  <= chunk;
                strb_o  <= (last_load && rem_q != '0) ? part_mask : '1;
                last_o  <= last_load;
                valid_o <= 1'b1;
                k       <= k + NBW'(1);
            end else if (handshake) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/neureka_accumulator_streamout.md
Name: neureka_accumulator_streamout

Overview:
- Drains the accumulator buffer after a tile completes.
- Slices the buffer's full parallel read-out into WIDTH_FACTOR-word beats and streams them to the streamer/normquant path over a valid/ready interface, with a byte-lane strobe and a last flag.
- Optionally pulses a clear to the buffer once the final beat is accepted.
- This is the read-side counterpart of the buffer's write ports.

Parameters:
- DATA_WIDTH, 8: width of one accumulator word in bits.
- NUM_WORDS, 32: number of buffer words. Must be a multiple of WIDTH_FACTOR.
- WIDTH_FACTOR, 8: words per output beat.
- LEN_WIDTH, localparam $clog2(NUM_WORDS+1): width of the length field.
- NUM_BEATS, localparam NUM_WORDS/WIDTH_FACTOR: maximum number of beats.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  launch drain; sampled only in IDLE.
- len_i  in  LEN_WIDTH  number of words to drain.
- clear_after_i  in  1  issue clear_o after the drain; sampled with start_i.
- rdata_all_i  in  NUM_WORDS*DATA_WIDTH  buffer contents; word i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
- clear_o  out  1  one-cycle clear request to the buffer.
- busy_o  out  1  high whenever state != IDLE; the controller blocks buffer writes while this is high.
- done_o  out  1  one-cycle completion pulse.
- valid_o  out  1  output beat valid.
- ready_i  in  1  consumer ready.
- data_o  out  WIDTH_FACTOR*DATA_WIDTH  beat data; word 0 in the LSBs.
- strb_o  out  WIDTH_FACTOR  per-word valid mask.
- last_o  out  1  marks the final beat.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - state=IDLE; all counters=0.
  - valid_o, last_o, clear_o, done_o, busy_o all 0; data_o=0, strb_o=0.
  - Reset overrides everything, including mid-drain: the pending beat is dropped, and no clear_o or done_o is issued.
- Length handling:
  - len_i > NUM_WORDS saturates to NUM_WORDS.
  - nbeats = ceil(len/WIDTH_FACTOR); rem = len mod WIDTH_FACTOR.
- State machine: IDLE, DRAIN, FLUSH, CLEAR, DONE.
  - IDLE & start_i & len!=0 → DRAIN. Latch nbeats, rem and clear_after; beat counter k=0.
  - IDLE & start_i & len==0 → DONE. No beats, no clear.
  - DRAIN: the output register loads chunk k when it is empty, or is being consumed this cycle (valid_o & ready_i).
    - Chunk k = words k*WIDTH_FACTOR .. k*WIDTH_FACTOR+WIDTH_FACTOR-1 of rdata_all_i, sampled at the load edge.
    - Each load increments k.
    - Loading beat nbeats-1 sets last_o=1 and moves to FLUSH.
  - FLUSH: hold until valid_o & ready_i, then go to CLEAR if clear_after is set, else DONE.
  - CLEAR: clear_o=1 for exactly one cycle, then DONE.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- Strobe: strb_o is all ones on every beat, except the last beat when rem!=0, where strb_o = (1<<rem)-1. data_o carries all WIDTH_FACTOR words regardless of strb.
- Handshake:
  - While valid_o=1 and ready_i=0, data_o, strb_o and last_o hold stable.
  - valid_o never drops without a handshake.
  - With ready_i held high, throughput is 1 beat/cycle with no bubbles.
- Latency: start_i sampled in cycle T → busy_o=1 at T+1, first valid_o at T+2.
- Completion timing: last beat accepted in cycle L → clear_o at L+1 and done_o at L+2 if clear_after is set; otherwise done_o at L+1.
- start_i outside IDLE is ignored; parameters are not re-latched.
- The drain reads the live buffer; content stability during the drain is guaranteed externally by busy_o gating.

Test Plan (DATA_WIDTH=8, WIDTH_FACTOR=8, NUM_WORDS=32, buffer word i = i+1):
- Full drain, no backpressure:
  - Stimulus: len=32, clear_after=0, ready_i=1, start in cycle T.
  - Required: 4 beats, valid_o in T+2..T+5; beat0 data_o=0x0807060504030201, beat3 data_o=0x201F1E1D1C1B1A19.
  - Required: strb_o=0xFF on every beat; last_o only on beat3; done_o at T+6; clear_o never asserted.
- Partial length:
  - Stimulus: len=13.
  - Required: 2 beats; beat1 data_o=0x100F0E0D0C0B0A09, strb_o=0x1F, last_o=1.
- Backpressure:
  - Stimulus: len=16, ready_i low for 3 cycles while beat0 is valid.
  - Required: beat0 stable for all stalled cycles, no beat lost or duplicated, exactly 2 handshakes.
- Clear after drain:
  - Stimulus: len=8, clear_after=1, ready_i=1.
  - Required: one beat; clear_o high exactly one cycle after its handshake; done_o one cycle later.
- Zero length and oversized length:
  - Stimulus: len=0.
  - Required: no valid_o; done_o at T+1; busy_o=1 only at T+1.
  - Stimulus: len=40.
  - Required: behaves as len=32.
- Reset and ignored start:
  - Stimulus: start asserted again while busy.
  - Required: start ignored; beat count unchanged.
  - Stimulus: rst_i asserted mid-drain (after beat1).
  - Required: next cycle valid_o=0, busy_o=0, no done_o or clear_o.
  - Stimulus: fresh start after reset.
  - Required: beat0 (data_o=0x0807060504030201) is streamed first.
